// File: rtl/onewire_pkg.sv
// onewire_pkg: shared definitions for the 1-Wire bus master.
//  - command op encodings (reserved op 3 behaves as RESET)
//  - FSM state encoding
//  - default timing constants in clk cycles
package onewire_pkg;

  localparam logic [1:0] OW_OP_RESET = 2'd0;
  localparam logic [1:0] OW_OP_WRITE = 2'd1;
  localparam logic [1:0] OW_OP_READ  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_RST_LOW,
    S_RST_WAIT,
    S_SLOT_LOW,
    S_SLOT_HIGH,
    S_SLOT_REC,
    S_DONE
  } ow_state_e;

  localparam int OW_T_GAP        = 2000;
  localparam int OW_T_RSTL       = 48000;
  localparam int OW_T_PRES_SAMPLE = 4000;
  localparam int OW_T_PRES_END   = 6000;
  localparam int OW_T_LOW0       = 3000;
  localparam int OW_T_LOW1       = 300;
  localparam int OW_T_SAMPLE     = 750;
  localparam int OW_T_SLOT       = 3500;
  localparam int OW_T_REC        = 100;

endpackage

// File: rtl/onewire_sync.sv
// onewire_sync: two-flop synchroniser for the bus pin.
//  clk   in  system clock
//  reset in  asynchronous, active-low; flops reset to 1 (idle bus level)
//  d     in  raw bus level
//  q     out synchronised bus level
module onewire_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/onewire_master_xfer.sv
// onewire_master_xfer: multi-bit 1-Wire bus master.
// Runs RESET/presence, WRITE and READ (LSB first, up to DATA_W bits) transactions
// taken from a valid/ready command port; reports on a one-cycle rsp_valid strobe.
//  clk, reset          clock, async active-low reset
//  cmd_valid/cmd_ready command handshake (ready only in IDLE)
//  cmd_op              0 RESET, 1 WRITE, 2 READ, 3 as RESET
//  cmd_nbits           bit count, clamped to DATA_W
//  cmd_wdata           write data, LSB first
//  rsp_valid           one-cycle end-of-transaction strobe
//  rsp_rdata           read data, bit i from slot i
//  rsp_presence        presence pulse seen (RESET)
//  rsp_err             bus found low before the transaction
//  busy                ~cmd_ready
//  port                open-drain bus pin (0 or z only)
module onewire_master_xfer
  import onewire_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int CNT_W         = 16,
  parameter int T_GAP         = OW_T_GAP,
  parameter int T_RSTL        = OW_T_RSTL,
  parameter int T_PRES_SAMPLE = OW_T_PRES_SAMPLE,
  parameter int T_PRES_END    = OW_T_PRES_END,
  parameter int T_LOW0        = OW_T_LOW0,
  parameter int T_LOW1        = OW_T_LOW1,
  parameter int T_SAMPLE      = OW_T_SAMPLE,
  parameter int T_SLOT        = OW_T_SLOT,
  parameter int T_REC         = OW_T_REC,
  localparam int NB_W         = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [NB_W-1:0]   cmd_nbits,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_presence,
  output logic              rsp_err,
  output logic              busy,
  inout  wire               port
);

  // terminal counts (all compares are against cnt == T-1, except the sample points)
  localparam logic [CNT_W-1:0] C_GAP  = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] C_RSTL = CNT_W'(T_RSTL - 1);
  localparam logic [CNT_W-1:0] C_PSMP = CNT_W'(T_PRES_SAMPLE);
  localparam logic [CNT_W-1:0] C_PEND = CNT_W'(T_PRES_END - 1);
  localparam logic [CNT_W-1:0] C_LOW0 = CNT_W'(T_LOW0 - 1);
  localparam logic [CNT_W-1:0] C_LOW1 = CNT_W'(T_LOW1 - 1);
  localparam logic [CNT_W-1:0] C_SAMP = CNT_W'(T_SAMPLE);
  localparam logic [CNT_W-1:0] C_SLOT = CNT_W'(T_SLOT - 1);
  localparam logic [CNT_W-1:0] C_REC  = CNT_W'(T_REC - 1);
  localparam logic [NB_W-1:0]  NB_MAX = NB_W'(DATA_W);

  ow_state_e         state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [1:0]        op_q;
  logic [NB_W-1:0]   nbits_q, bit_idx;
  logic [DATA_W-1:0] wdata_q;   // shifts right; bit 0 is the current slot's bit
  logic [DATA_W-1:0] bmask;     // one-hot pointer at the current read slot
  logic [DATA_W-1:0] rdata_q;
  logic              presence_q, err_q;
  logic              bus_s;

  logic              accept, is_rst, is_read, last_bit, drv_low;
  logic [CNT_W-1:0]  low_end;

  onewire_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (port),
    .q     (bus_s)
  );

  assign cmd_ready    = (state == S_IDLE);
  assign busy         = ~cmd_ready;
  assign rsp_valid    = (state == S_DONE);
  assign rsp_rdata    = rdata_q;
  assign rsp_presence = presence_q;
  assign rsp_err      = err_q;

  assign accept   = cmd_valid & cmd_ready;
  assign is_read  = (op_q == OW_OP_READ);
  assign is_rst   = (op_q != OW_OP_WRITE) & ~is_read;
  assign last_bit = (bit_idx == nbits_q - NB_W'(1));
  assign low_end  = (!is_read && !wdata_q[0]) ? C_LOW0 : C_LOW1;

  // drive is decoded from the state register, so an async reset releases the pin at once
  assign drv_low = (state == S_RST_LOW) || (state == S_SLOT_LOW);
  assign port    = drv_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (cmd_valid) state_n = S_GAP;
      end
      S_GAP: begin
        if (!bus_s) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end else if (cnt == C_GAP) begin
          cnt_n = '0;
          if (is_rst)              state_n = S_RST_LOW;
          else if (nbits_q == '0)  state_n = S_DONE;
          else                     state_n = S_SLOT_LOW;
        end
      end
      S_RST_LOW: if (cnt == C_RSTL) begin
        cnt_n   = '0;
        state_n = S_RST_WAIT;
      end
      S_RST_WAIT: if (cnt == C_PEND) begin
        cnt_n   = '0;
        state_n = S_DONE;
      end
      // slot counter keeps running from LOW into HIGH: T_SLOT/T_SAMPLE are slot-relative
      S_SLOT_LOW: if (cnt == low_end) state_n = S_SLOT_HIGH;
      S_SLOT_HIGH: if (cnt == C_SLOT) begin
        cnt_n   = '0;
        state_n = S_SLOT_REC;
      end
      S_SLOT_REC: if (cnt == C_REC) begin
        cnt_n   = '0;
        state_n = last_bit ? S_DONE : S_SLOT_LOW;
      end
      S_DONE: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= OW_OP_RESET;
      nbits_q    <= '0;
      bit_idx    <= '0;
      wdata_q    <= '0;
      bmask      <= '0;
      rdata_q    <= '0;
      presence_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (accept) begin
      op_q       <= cmd_op;
      nbits_q    <= (cmd_nbits > NB_MAX) ? NB_MAX : cmd_nbits;
      bit_idx    <= '0;
      wdata_q    <= cmd_wdata;
      bmask      <= DATA_W'(1);
      rdata_q    <= '0;
      presence_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // stuck-low abort happens before any sample, so presence/rdata stay cleared
      if (state == S_GAP && !bus_s) err_q <= 1'b1;
      if (state == S_RST_WAIT && cnt == C_PSMP) presence_q <= ~bus_s;
      if (state == S_SLOT_HIGH && cnt == C_SAMP && is_read && bus_s)
        rdata_q <= rdata_q | bmask;
      if (state == S_SLOT_REC && cnt == C_REC && !last_bit) begin
        bit_idx <= bit_idx + NB_W'(1);
        wdata_q <= wdata_q >> 1;
        bmask   <= bmask << 1;
      end
    end
  end

endmodule

// File: tb/tb_onewire_master_xfer.sv
// Bench for onewire_master_xfer with timing scaled down 10x (presence sample moved
// inside the slave's pulse). Models the pull-up and a slave (presence responder,
// read responder, stuck-low); checks responses, latencies and bus low widths
// against expectations computed from the protocol rules.
module tb_onewire_master_xfer;
  import onewire_pkg::*;

  localparam int DATA_W = 8;
  localparam int NB_W   = $clog2(DATA_W + 1);
  localparam int T_GAP = 200, T_RSTL = 4800, T_PS = 150, T_PE = 600;
  localparam int T_L0 = 300, T_L1 = 30, T_SAMP = 75, T_SLOT = 350, T_REC = 10;
  localparam int BUDGET = 20000;

  logic              clk = 1'b0, reset = 1'b1;
  logic              cmd_valid = 1'b0, cmd_ready;
  logic [1:0]        cmd_op = '0;
  logic [NB_W-1:0]   cmd_nbits = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid, rsp_presence, rsp_err, busy;
  logic [DATA_W-1:0] rsp_rdata;
  wire               port;
  logic              slv_low = 1'b0;

  assign port = slv_low ? 1'b0 : 1'bz;
  pullup (port);

  always #5 clk = ~clk;

  onewire_master_xfer #(
    .DATA_W(DATA_W), .CNT_W(16), .T_GAP(T_GAP), .T_RSTL(T_RSTL),
    .T_PRES_SAMPLE(T_PS), .T_PRES_END(T_PE), .T_LOW0(T_L0), .T_LOW1(T_L1),
    .T_SAMPLE(T_SAMP), .T_SLOT(T_SLOT), .T_REC(T_REC)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_nbits(cmd_nbits), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_presence(rsp_presence),
    .rsp_err(rsp_err), .busy(busy), .port(port)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // bus monitor + slave; 0 idle, 1 presence, 2 read responder, 3 stuck low
  int                slv_mode = 0;
  logic [DATA_W-1:0] rd_pat = '0;   // bit=0 -> slave holds that slot low
  int                p_start = 10, p_end = 300;
  int                widths[$];
  int                run = 0, since_rel = -1, hold = 0, rbit = 0;
  logic              port_d = 1'b1;

  always @(negedge clk) begin
    logic p;
    int   last_run;
    p = port;
    last_run = run;
    if (!p) run++;
    else begin
      if (run > 0) widths.push_back(run);
      run = 0;
    end
    if (slv_mode == 0) begin
      slv_low = 1'b0; rbit = 0; hold = 0; since_rel = -1;
    end else if (slv_mode == 3) begin
      slv_low = 1'b1;
    end else if (slv_mode == 1) begin
      if (p && last_run >= 1000) since_rel = 0;
      else if (since_rel >= 0) since_rel++;
      slv_low = (since_rel >= p_start) && (since_rel < p_end);
    end else begin
      if (!slv_low && !p && port_d) begin
        if (rbit < DATA_W && !rd_pat[rbit]) hold = 150;
        rbit++;
      end
      if (hold > 0) begin slv_low = 1'b1; hold--; end
      else slv_low = 1'b0;
    end
    port_d = p;
  end

  task automatic xfer(input logic [1:0] op, input int nb, input logic [DATA_W-1:0] wd,
                      input bit pres, input logic [DATA_W-1:0] pat,
                      input int ps, input int pe, input string nm);
    int n, lat, w0, exp_lat;
    logic [DATA_W-1:0] exp_rd;
    bit exp_pres, rst_op;
    n = (nb > DATA_W) ? DATA_W : nb;
    rst_op = (op == OW_OP_RESET) || (op == 2'd3);
    slv_mode = 0;
    @(negedge clk);
    rd_pat = pat; p_start = ps; p_end = pe;
    slv_mode = (op == OW_OP_READ) ? 2 : ((rst_op && pres) ? 1 : 0);
    exp_rd = '0; exp_pres = 1'b0;
    if (rst_op) begin
      exp_lat = T_GAP + T_RSTL + T_PE;
      exp_pres = pres;
    end else begin
      exp_lat = T_GAP + n * (T_SLOT + T_REC);
      if (op == OW_OP_READ) for (int i = 0; i < n; i++) exp_rd[i] = pat[i];
    end
    w0 = widths.size();
    chk({nm, "_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_nbits = NB_W'(nb); cmd_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_wdata = DATA_W'($urandom);
    chk({nm, "_busy"}, busy, 1);
    lat = 0;
    while (!rsp_valid && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= BUDGET) begin
      chk({nm, "_timeout"}, 1, 0);
      return;
    end
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_rdata"}, rsp_rdata, exp_rd);
    chk({nm, "_pres"}, rsp_presence, exp_pres);
    chk({nm, "_err"}, rsp_err, 0);
    if (op == OW_OP_WRITE) begin
      chk({nm, "_npulse"}, widths.size() - w0, n);
      for (int i = 0; i < n && w0 + i < widths.size(); i++)
        chk($sformatf("%s_w%0d", nm, i), widths[w0 + i], wd[i] ? T_L1 : T_L0);
    end else if (rst_op) begin
      if (widths.size() > w0) chk({nm, "_rstl"}, widths[w0], T_RSTL);
      else chk({nm, "_rstl_missing"}, 0, 1);
    end
    @(negedge clk);
    chk({nm, "_strobe"}, rsp_valid, 0);
    chk({nm, "_hold"}, rsp_rdata, exp_rd);
    chk({nm, "_idle"}, cmd_ready, 1);
  endtask

  initial begin
    int lat;
    bit seen;
    #2 reset = 1'b0;
    #1;
    chk("rst_port", port, 1);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_pres", rsp_presence, 0);
    chk("rst_err", rsp_err, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    xfer(OW_OP_RESET, 0, '0, 1'b1, '0, 10, 300, "rst_slave");
    xfer(OW_OP_RESET, 0, '0, 1'b0, '0, 10, 300, "rst_none");
    xfer(OW_OP_WRITE, 8, 8'hA5, 1'b0, '0, 10, 300, "wr_a5");
    xfer(OW_OP_READ, 8, '0, 1'b0, 8'hF2, 10, 300, "rd_f2");
    xfer(OW_OP_READ, 0, '0, 1'b0, 8'h00, 10, 300, "rd_n0");

    for (int k = 0; k < 7; k++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      xfer(op, $urandom_range(0, 15), DATA_W'($urandom), 1'($urandom), DATA_W'($urandom),
           $urandom_range(5, 60), $urandom_range(250, 500), $sformatf("rnd%0d", k));
    end

    // stuck-low bus: abort in GAP with error and nothing sampled
    slv_mode = 3;
    repeat (5) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OW_OP_READ; cmd_nbits = NB_W'(8); cmd_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    chk("stuck_lat_ok", lat <= T_GAP + 3, 1);
    chk("stuck_err", rsp_err, 1);
    chk("stuck_rdata", rsp_rdata, 0);
    chk("stuck_pres", rsp_presence, 0);
    slv_mode = 0;
    repeat (10) @(negedge clk);

    // reset in the middle of the reset pulse
    cmd_valid = 1'b1; cmd_op = OW_OP_RESET; cmd_nbits = '0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (T_GAP + 100) @(negedge clk);
    chk("abort_drive", port, 0);
    #2 reset = 1'b0;
    #1;
    chk("abort_port", port, 1);
    chk("abort_ready", cmd_ready, 1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    reset = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (rsp_valid || port == 1'b0) seen = 1'b1;
    end
    chk("abort_quiet", seen, 0);
    xfer(OW_OP_WRITE, 3, 8'h06, 1'b0, '0, 10, 300, "post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
